// File: rtl/dmem_arbiter_if.sv
// Data-memory arbitration bundle: pipeline MEM-stage port, debug/loader port and the
// single-port data-memory port. The arbiter uses the slave view; requesters/memory use master.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DM_ADDRESS = 9
);
    // Pipeline MEM stage
    logic                  p_MemRead;
    logic                  p_MemWrite;
    logic [DM_ADDRESS-1:0] p_addr;
    logic [DATA_W-1:0]     p_wdata;
    logic [2:0]            p_funct3;
    logic [DATA_W-1:0]     p_rdata;
    logic                  p_stall;

    // Debug / loader
    logic                  d_req;
    logic                  d_we;
    logic [DM_ADDRESS-1:0] d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [2:0]            d_funct3;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    // Data memory
    logic                  m_MemRead;
    logic                  m_MemWrite;
    logic [DM_ADDRESS-1:0] m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [2:0]            m_funct3;
    logic [DATA_W-1:0]     m_rdata;

    modport slave (
        input  p_MemRead, p_MemWrite, p_addr, p_wdata, p_funct3,
        output p_rdata, p_stall,
        input  d_req, d_we, d_addr, d_wdata, d_funct3,
        output d_gnt, d_rvalid, d_rdata,
        output m_MemRead, m_MemWrite, m_addr, m_wdata, m_funct3,
        input  m_rdata
    );

    modport master (
        output p_MemRead, p_MemWrite, p_addr, p_wdata, p_funct3,
        input  p_rdata, p_stall,
        output d_req, d_we, d_addr, d_wdata, d_funct3,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_MemRead, m_MemWrite, m_addr, m_wdata, m_funct3,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: the pipeline has priority, debug takes idle slots and
// is force-granted for one cycle after STARVE_LIMIT consecutive denied cycles.
module dmem_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DM_ADDRESS   = 9,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        StPipe,
        StForce
    } state_e;

    localparam logic [3:0] LastWait = 4'(STARVE_LIMIT - 1);

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic p_active;
    logic pipe_gnt;
    logic dbg_gnt;
    logic dbg_denied;

    // Grant decode and memory drive; every grant is qualified by reset so nothing leaks
    // onto the memory port while reset is held.
    always_comb begin
        p_active = bus.p_MemRead | bus.p_MemWrite;
        pipe_gnt = (state_q == StPipe) && p_active && !reset;
        dbg_gnt  = bus.d_req && (!p_active || (state_q == StForce)) && !reset;

        bus.d_gnt    = dbg_gnt;
        bus.p_stall  = (state_q == StForce) && bus.d_req && p_active && !reset;
        bus.p_rdata  = bus.m_rdata;
        bus.d_rvalid = d_rvalid_q;
        bus.d_rdata  = d_rdata_q;

        bus.m_MemRead  = 1'b0;
        bus.m_MemWrite = 1'b0;
        bus.m_addr     = bus.p_addr;
        bus.m_wdata    = bus.p_wdata;
        bus.m_funct3   = bus.p_funct3;

        if (dbg_gnt) begin
            bus.m_MemRead  = ~bus.d_we;
            bus.m_MemWrite = bus.d_we;
            bus.m_addr     = bus.d_addr;
            bus.m_wdata    = bus.d_wdata;
            bus.m_funct3   = bus.d_funct3;
        end else if (pipe_gnt) begin
            bus.m_MemRead  = bus.p_MemRead;
            bus.m_MemWrite = bus.p_MemWrite;
        end
    end

    // Starvation tracking: FORCE is a single-cycle slot, after which counting restarts.
    always_comb begin
        state_d    = StPipe;
        wait_cnt_d = 4'd0;
        dbg_denied = (state_q == StPipe) && bus.d_req && p_active;

        unique case (state_q)
            StPipe: begin
                if (dbg_denied) begin
                    if (wait_cnt_q == LastWait) begin
                        state_d = StForce;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
            end
            StForce: begin
                state_d = StPipe;
            end
            default: begin
                state_d = StPipe;
            end
        endcase

        d_rvalid_d = dbg_gnt && !bus.d_we;
        d_rdata_d  = d_rvalid_d ? bus.m_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StPipe;
            wait_cnt_q <= 4'd0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then random traffic, checked against
// a slot-level reference model of the arbitration rules and a word-per-address memory.
module tb_dmem_arbiter;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned DM_ADDRESS   = 9;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned MemWords     = 2 ** DM_ADDRESS;

    typedef struct {
        int          cyc;
        bit          rst;
        bit          gnt;
        bit          stall;
        bit          mrd;
        bit          mwr;
        bit          chk_bus;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        bit          chk_rd;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic reset;
    bit   mem_init;

    dmem_arbiter_if #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS)) bus ();

    dmem_arbiter #(
        .DATA_W      (DATA_W),
        .DM_ADDRESS  (DM_ADDRESS),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'hA5000000 ^ (i * 32'h00010203);
    endfunction

    // Environment memory: combinational read, write on the clock edge.
    logic [31:0] env_mem [MemWords];
    assign bus.m_rdata = env_mem[bus.m_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(MemWords); i++) env_mem[i] <= init_word(i);
        end else if (bus.m_MemWrite) begin
            env_mem[bus.m_addr] <= bus.m_wdata;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [MemWords];
    int unsigned starved;
    int          cyc;
    exp_t        expq[$];
    rd_t         rdq[$];

    int checks;
    int failures;
    int mon_cyc;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, mon_cyc, act, exp);
        end
    endfunction

    // One cycle of stimulus; the model decides who owns the slot and queues expectations.
    task automatic step(input bit rst, input bit pr, input bit pw, input logic [8:0] pa,
                        input logic [31:0] pwd, input logic [2:0] pf3, input bit dr,
                        input bit dwe, input logic [8:0] da, input logic [31:0] dwd,
                        input logic [2:0] df3, output bit dgnt);
        exp_t e;
        bit   p_act;
        @(negedge clk);
        reset          = rst;
        bus.p_MemRead  = pr;
        bus.p_MemWrite = pw;
        bus.p_addr     = pa;
        bus.p_wdata    = pwd;
        bus.p_funct3   = pf3;
        bus.d_req      = dr;
        bus.d_we       = dwe;
        bus.d_addr     = da;
        bus.d_wdata    = dwd;
        bus.d_funct3   = df3;
        #1;
        cyc++;
        e         = '{default: 0};
        e.cyc     = cyc;
        e.addr    = pa;
        e.wdata   = pwd;
        e.f3      = pf3;
        e.chk_bus = !rst;
        dgnt      = 1'b0;
        p_act     = pr | pw;
        if (rst) begin
            e.rst   = 1'b1;
            starved = 0;
            rdq.delete();
        end else begin
            if (starved == STARVE_LIMIT) begin
                starved = 0;
                if (dr) begin
                    dgnt    = 1'b1;
                    e.stall = p_act;
                end
            end else if (p_act) begin
                e.mrd = pr;
                e.mwr = pw;
                if (pr) begin
                    e.chk_rd = 1'b1;
                    e.rdata  = ref_mem[pa];
                end
                if (pw) ref_mem[pa] = pwd;
                starved = dr ? starved + 1 : 0;
            end else begin
                starved = 0;
                dgnt    = dr;
            end
            if (dgnt) begin
                e.gnt   = 1'b1;
                e.mrd   = !dwe;
                e.mwr   = dwe;
                e.addr  = da;
                e.wdata = dwd;
                e.f3    = df3;
                if (dwe) ref_mem[da] = dwd;
                else rdq.push_back('{due: cyc + 1, data: ref_mem[da]});
            end
        end
        expq.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    exp_t me;
    rd_t  mr;
    bit   exp_rv;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            while (expq.size() > 0) begin
                me      = expq.pop_front();
                mon_cyc = me.cyc;
                chk("d_gnt", 32'(bus.d_gnt), 32'(me.gnt));
                chk("p_stall", 32'(bus.p_stall), 32'(me.stall));
                chk("m_MemRead", 32'(bus.m_MemRead), 32'(me.mrd));
                chk("m_MemWrite", 32'(bus.m_MemWrite), 32'(me.mwr));
                if (me.chk_bus) begin
                    chk("m_addr", 32'(bus.m_addr), 32'(me.addr));
                    chk("m_wdata", bus.m_wdata, me.wdata);
                    chk("m_funct3", 32'(bus.m_funct3), 32'(me.f3));
                end
                if (me.chk_rd) chk("p_rdata", bus.p_rdata, me.rdata);
                if (me.rst) chk("d_rdata_reset", bus.d_rdata, 32'h0);
                exp_rv = (rdq.size() > 0) && (rdq[0].due == me.cyc);
                chk("d_rvalid", 32'(bus.d_rvalid), 32'(exp_rv));
                if (exp_rv) begin
                    mr = rdq.pop_front();
                    chk("d_rdata", bus.d_rdata, mr.data);
                end
            end
        end
    end

    // Random-phase debug request state
    bit          r_dr;
    bit          r_dwe;
    logic [8:0]  r_da;
    logic [31:0] r_dwd;
    logic [2:0]  r_df3;

    task automatic new_dreq();
        r_dr  = 1'b1;
        r_dwe = 1'($urandom_range(0, 1));
        r_da  = 9'(4 * $urandom_range(0, 15));
        r_dwd = $urandom;
        r_df3 = 3'($urandom_range(0, 7));
    endtask

    initial begin : stim
        bit          g;
        int          pm;
        bit          pr, pw, rs;
        logic [8:0]  pa;
        logic [31:0] pwd;
        logic [2:0]  pf3;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        starved  = 0;
        mem_init = 1'b1;
        reset    = 1'b1;
        for (int i = 0; i < int'(MemWords); i++) ref_mem[i] = init_word(i);

        // Reset holds everything quiet even with both sides requesting
        step(1, 1, 0, 9'h010, 32'h0, 3'b010, 1, 0, 9'h020, 32'h0, 3'b010, g);
        step(1, 1, 0, 9'h010, 32'h0, 3'b010, 1, 1, 9'h020, 32'h1, 3'b010, g);
        mem_init = 1'b0;

        // Pipeline-only reads
        repeat (3) step(0, 1, 0, 9'h010, 32'h0, 3'b010, 0, 0, 9'h000, 32'h0, 3'b000, g);

        // Debug write in an idle slot, then pipeline reads it back
        step(0, 0, 0, 9'h000, 32'h0, 3'b000, 1, 1, 9'h020, 32'hDEADBEEF, 3'b010, g);
        step(0, 1, 0, 9'h020, 32'h0, 3'b010, 0, 0, 9'h000, 32'h0, 3'b000, g);

        // Starved debug read: forced on the fifth cycle
        repeat (5) step(0, 1, 0, 9'h040, 32'h0, 3'b010, 1, 0, 9'h020, 32'h0, 3'b010, g);
        step(0, 1, 0, 9'h044, 32'h0, 3'b010, 0, 0, 9'h000, 32'h0, 3'b000, g);

        // Simultaneous writes to one address: pipeline wins
        step(0, 0, 1, 9'h030, 32'h11111111, 3'b010, 1, 1, 9'h030, 32'h22222222, 3'b010, g);
        step(0, 0, 0, 9'h000, 32'h0, 3'b000, 0, 0, 9'h000, 32'h0, 3'b000, g);

        // Reset landing on the forced slot restarts the starvation count
        repeat (4) step(0, 1, 0, 9'h050, 32'h0, 3'b010, 1, 0, 9'h030, 32'h0, 3'b010, g);
        repeat (2) step(1, 1, 0, 9'h050, 32'h0, 3'b010, 1, 0, 9'h030, 32'h0, 3'b010, g);
        repeat (5) step(0, 1, 0, 9'h050, 32'h0, 3'b010, 1, 0, 9'h030, 32'h0, 3'b010, g);
        // Reset right after a granted read discards its d_rvalid
        step(1, 0, 0, 9'h000, 32'h0, 3'b000, 0, 0, 9'h000, 32'h0, 3'b000, g);
        step(0, 0, 0, 9'h000, 32'h0, 3'b000, 0, 0, 9'h000, 32'h0, 3'b000, g);

        // Request withdrawn in the forced slot
        repeat (4) step(0, 1, 0, 9'h060, 32'h0, 3'b010, 1, 1, 9'h060, 32'h33333333, 3'b010, g);
        step(0, 1, 0, 9'h060, 32'h0, 3'b010, 0, 0, 9'h000, 32'h0, 3'b000, g);
        step(0, 1, 0, 9'h064, 32'h0, 3'b010, 1, 1, 9'h060, 32'h44444444, 3'b010, g);
        step(0, 0, 0, 9'h000, 32'h0, 3'b000, 1, 1, 9'h060, 32'h44444444, 3'b010, g);

        // Random traffic
        r_dr = 1'b0;
        new_dreq();
        r_dr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            pm  = int'($urandom_range(0, 9));
            pr  = (pm < 4);
            pw  = (pm >= 4) && (pm < 7);
            pa  = 9'(4 * $urandom_range(0, 15));
            pwd = $urandom;
            pf3 = 3'($urandom_range(0, 7));
            if (!r_dr && $urandom_range(0, 2) == 0) new_dreq();
            else if (r_dr && $urandom_range(0, 31) == 0) r_dr = 1'b0;
            rs = ($urandom_range(0, 199) == 0);
            step(rs, pr, pw, pa, pwd, pf3, r_dr, r_dwe, r_da, r_dwd, r_df3, g);
            if (rs) r_dr = 1'b0;
            if (g) begin
                if ($urandom_range(0, 1) == 1) new_dreq();
                else r_dr = 1'b0;
            end
        end

        repeat (3) step(0, 0, 0, 9'h000, 32'h0, 3'b000, 0, 0, 9'h000, 32'h0, 3'b000, g);
        @(negedge clk);
        #5;
        chk("rvalid_outstanding", 32'(rdq.size()), 32'h0);
        chk("exp_outstanding", 32'(expq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
